// File: rtl/bus_arbiter.sv
// rtl/bus_arbiter.sv - round-robin arbiter sharing one bus slave port between hart masters
//
// Purpose: grants the shared slave port to one requesting master at a time,
// rotating priority after each grant, and keeps ownership with a master for
// the whole of an atomic (LR/SC/AMO) sequence.
//
// Ports:
//   i_clk, i_rst        clock, asynchronous active-low reset
//   i_m_bus_en/wr_en/atomic   per-master request, write, lock-request bits
//   i_m_addr/wr_data/byte_en  per-master packed request payload (master k at [k*W +: W])
//   o_m_ack             one-hot completion strobe to the owning master
//   o_m_rd_data         slave read data, broadcast to all masters
//   o_bus_en, o_wr_en, o_addr, o_wr_data, o_byte_en   registered shared slave port
//   i_ack, i_rd_data    slave completion and read data
//   o_grant             current/last owner index
module bus_arbiter #(
  parameter int N_MASTERS = 2,
  parameter int XLEN      = 32,
  localparam int GW       = $clog2(N_MASTERS),
  localparam int BW       = XLEN / 8
) (
  input  logic                      i_clk,
  input  logic                      i_rst,
  input  logic [N_MASTERS-1:0]      i_m_bus_en,
  input  logic [N_MASTERS-1:0]      i_m_wr_en,
  input  logic [N_MASTERS-1:0]      i_m_atomic,
  input  logic [N_MASTERS*XLEN-1:0] i_m_addr,
  input  logic [N_MASTERS*XLEN-1:0] i_m_wr_data,
  input  logic [N_MASTERS*BW-1:0]   i_m_byte_en,
  output logic [N_MASTERS-1:0]      o_m_ack,
  output logic [XLEN-1:0]           o_m_rd_data,
  output logic                      o_bus_en,
  output logic                      o_wr_en,
  output logic [XLEN-1:0]           o_addr,
  output logic [XLEN-1:0]           o_wr_data,
  output logic [BW-1:0]             o_byte_en,
  input  logic                      i_ack,
  input  logic [XLEN-1:0]           i_rd_data,
  output logic [GW-1:0]             o_grant
);

  typedef enum logic [1:0] {IDLE = 2'd0, BUSY = 2'd1, DONE = 2'd2} state_t;

  state_t          state_q, state_d;
  logic            lock_q, lock_d;
  logic [GW-1:0]   last_grant_q, last_grant_d;
  logic [GW-1:0]   grant_q, grant_d;
  logic            bus_en_q, bus_en_d;
  logic            wr_en_q, wr_en_d;
  logic [XLEN-1:0] addr_q, addr_d;
  logic [XLEN-1:0] wr_data_q, wr_data_d;
  logic [BW-1:0]   byte_en_q, byte_en_d;

  // Round-robin search: first requester after last_grant, wrapping.
  logic          rr_found;
  logic [GW-1:0] rr_pick;
  logic [GW-1:0] rr_idx;

  always_comb begin
    rr_found = 1'b0;
    rr_pick  = last_grant_q;
    rr_idx   = last_grant_q;
    for (int i = 1; i <= N_MASTERS; i++) begin
      rr_idx = GW'((int'(last_grant_q) + i) % N_MASTERS);
      if (!rr_found && i_m_bus_en[rr_idx]) begin
        rr_found = 1'b1;
        rr_pick  = rr_idx;
      end
    end
  end

  // State and datapath registers.
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      state_q      <= IDLE;
      lock_q       <= 1'b0;
      last_grant_q <= GW'(N_MASTERS - 1);
      grant_q      <= '0;
      bus_en_q     <= 1'b0;
      wr_en_q      <= 1'b0;
      addr_q       <= '0;
      wr_data_q    <= '0;
      byte_en_q    <= '0;
    end else begin
      state_q      <= state_d;
      lock_q       <= lock_d;
      last_grant_q <= last_grant_d;
      grant_q      <= grant_d;
      bus_en_q     <= bus_en_d;
      wr_en_q      <= wr_en_d;
      addr_q       <= addr_d;
      wr_data_q    <= wr_data_d;
      byte_en_q    <= byte_en_d;
    end
  end

  // Next-state and register-input logic.
  logic          take;
  logic [GW-1:0] take_idx;

  always_comb begin
    state_d      = state_q;
    lock_d       = lock_q;
    last_grant_d = last_grant_q;
    grant_d      = grant_q;
    bus_en_d     = bus_en_q;
    wr_en_d      = wr_en_q;
    addr_d       = addr_q;
    wr_data_d    = wr_data_q;
    byte_en_d    = byte_en_q;
    take         = 1'b0;
    take_idx     = last_grant_q;

    case (state_q)
      IDLE: begin
        if (lock_q) begin
          // Locked: only the owner may go; dropping atomic releases the lock
          // and arbitration reopens on the following cycle.
          if (!i_m_atomic[last_grant_q]) begin
            lock_d = 1'b0;
          end else if (i_m_bus_en[last_grant_q]) begin
            take     = 1'b1;
            take_idx = last_grant_q;
          end
        end else if (rr_found) begin
          take     = 1'b1;
          take_idx = rr_pick;
        end
        if (take) begin
          state_d      = BUSY;
          last_grant_d = take_idx;
          grant_d      = take_idx;
          bus_en_d     = 1'b1;
          wr_en_d      = i_m_wr_en[take_idx];
          addr_d       = i_m_addr[int'(take_idx)*XLEN +: XLEN];
          wr_data_d    = i_m_wr_data[int'(take_idx)*XLEN +: XLEN];
          byte_en_d    = i_m_byte_en[int'(take_idx)*BW +: BW];
          lock_d       = i_m_atomic[take_idx];
        end
      end
      BUSY: begin
        // Withdrawn requests do not abort; only the slave ack ends the transfer.
        if (i_ack) begin
          bus_en_d = 1'b0;
          state_d  = DONE;
        end
      end
      DONE: begin
        // Dead cycle so the owner can retire its registered request.
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Outputs.
  always_comb begin
    o_m_ack = '0;
    if (state_q == BUSY && i_ack) begin
      o_m_ack[grant_q] = 1'b1;
    end
  end

  assign o_m_rd_data = i_rd_data;
  assign o_bus_en    = bus_en_q;
  assign o_wr_en     = wr_en_q;
  assign o_addr      = addr_q;
  assign o_wr_data   = wr_data_q;
  assign o_byte_en   = byte_en_q;
  assign o_grant     = grant_q;

endmodule

// File: doc/bus_arbiter.md
# bus_arbiter

Round-robin arbiter that shares one system bus slave port between `N_MASTERS` hart bus masters in the multi-core build. Each hart top presents the standard bus master port: enable, write enable, write data, address, byte enables; ack and read data come back. The arbiter registers the winning request onto the shared port, routes the ack and read data back to the owner, and holds ownership across atomic (LR/SC/AMO) sequences.

## Interface
- `N_MASTERS`, 2: number of requesting harts, legal range 2..8.
- `XLEN`, 32: address/data width.
- `i_clk` input 1: clock; all state on rising edge.
- `i_rst` input 1: reset, asynchronous, active-low.
- `i_m_bus_en` input N_MASTERS: per-master request.
- `i_m_wr_en` input N_MASTERS: per-master write (1) / read (0).
- `i_m_atomic` input N_MASTERS: per-master lock request, high for the whole atomic sequence.
- `i_m_addr` input N_MASTERS*XLEN: packed addresses, master k at [k*XLEN +: XLEN].
- `i_m_wr_data` input N_MASTERS*XLEN: packed write data, same packing.
- `i_m_byte_en` input N_MASTERS*(XLEN/8): packed byte enables.
- `o_m_ack` output N_MASTERS: one-hot completion strobe to the owner.
- `o_m_rd_data` output XLEN: read data, broadcast to all masters, valid with `o_m_ack`.
- `o_bus_en`, `o_wr_en` output 1; `o_addr`, `o_wr_data` output XLEN; `o_byte_en` output XLEN/8: shared slave port, all registered.
- `i_ack` input 1, `i_rd_data` input XLEN: slave completion and read data.
- `o_grant` output $clog2(N_MASTERS): current/last owner index, debug.

## Operation
- States: IDLE, BUSY, DONE.
- IDLE, not locked: search requesters starting at `last_grant+1`, wrapping modulo N_MASTERS. The first set `i_m_bus_en[k]` wins. Register k into `last_grant`/`o_grant`. Latch master k's wr_en/addr/wr_data/byte_en into the slave outputs. Set `o_bus_en`. Capture `lock <= i_m_atomic[k]`. Go to BUSY.
- IDLE, locked: only the lock owner `last_grant` is eligible; other requests wait. If `i_m_atomic[last_grant]==0` in IDLE, clear lock; normal arbitration resumes the next cycle.
- BUSY: hold all slave outputs stable until `i_ack`. On `i_ack`:
  - `o_m_ack[o_grant]=1` combinationally that cycle.
  - `o_m_rd_data=i_rd_data`.
  - Clear `o_bus_en` at the next edge.
  - Go to DONE.
- DONE: one dead cycle with no grant, so the owner can drop its registered `i_m_bus_en`. Then go to IDLE.
- `o_m_ack` is 0 outside BUSY. A spurious `i_ack` in IDLE/DONE is ignored.
- A requester that withdraws its request during BUSY does not abort the transfer; the arbiter still waits for `i_ack`.
- `o_m_rd_data` follows `i_rd_data` at all times; it is qualified only by `o_m_ack`.
- Fairness: without lock, a continuously requesting master waits at most N_MASTERS-1 transactions.

## Timing
- Reset (`i_rst` low), asynchronous, including mid-transaction:
  - State IDLE, lock=0, `last_grant=N_MASTERS-1` (master 0 wins first).
  - All slave outputs 0, `o_grant=0`.
  - An in-flight transfer is dropped with no ack.
- Request sampled at edge E drives `o_bus_en` from E (registered), so latency is 1 cycle.
- If ack arrives in cycle A: `o_m_ack` is high in A only, `o_bus_en` is low from A+1, DONE is A+1, IDLE is A+2, and the next grant edge is end of A+2.
- Minimum gap between transactions is 2 low cycles of `o_bus_en`.
- A same-cycle ack is possible the cycle after the grant (zero-wait slave): BUSY lasts 1 cycle.

## Test plan
- Single master: m0 reads 0x100; slave acks 3 cycles after `o_bus_en`, returning 0xDEADBEEF -> `o_addr=0x100`, `o_wr_en=0`, `o_m_ack=2'b01` for exactly 1 cycle with `o_m_rd_data=0xDEADBEEF`.
- Simultaneous: m0 and m1 request in the same cycle after reset, zero-wait slave -> m0 is served first, then m1, with `o_bus_en` low for 2 cycles between them; a continued m0 request is then served after m1.
- N_MASTERS=4, all requesting continuously -> grant order 0,1,2,3,0,… and no master is starved.
- Lock: m1 issues a read with atomic=1, then a write; m0 requests throughout -> m0 is not granted until m1 drops atomic in IDLE, and `o_addr`/`o_wr_data` show m1's write with byte_en 4'hF.
- Async reset asserted mid-BUSY, before ack -> all outputs 0 immediately, no `o_m_ack`; after release, m0 has priority.
- Spurious `i_ack` pulses in IDLE and in DONE -> `o_m_ack` stays 0 and the state is unchanged.
